// File: rtl/scan_seq_pkg.sv
// scan_seq_pkg: shared constants and FSM state type for the channel scan sequencer
package scan_seq_pkg;
   localparam int NUM_CH = 8;
   localparam int CH_W = 3;
   typedef enum logic [1:0] {S_IDLE, S_DWELL, S_FINISH} scan_state_t;
endpackage

// File: rtl/scan_next_ch.sv
// scan_next_ch: finds the nearest enabled channel above cur, optionally searching circularly
module scan_next_ch
   import scan_seq_pkg::*;
(
   input  logic [NUM_CH-1:0] mask,
   input  logic [CH_W-1:0]   cur,
   input  logic              wrap,
   output logic [CH_W-1:0]   nxt,
   output logic              found
);
   logic [CH_W:0] s;
   // Walk from farthest to nearest so the nearest hit is the last one assigned
   always_comb begin
      nxt = '0;
      found = 1'b0;
      s = '0;
      for (int k = NUM_CH; k >= 1; k--) begin
         s = {1'b0, cur} + (CH_W+1)'(k);
         if (mask[s[CH_W-1:0]] && (wrap || !s[CH_W])) begin
            nxt = s[CH_W-1:0];
            found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/scan_sequencer.sv
// scan_sequencer: steps a 3-bit channel code through enabled channels, holding each
// for a programmable dwell, in single-pass or continuous mode
module scan_sequencer
   import scan_seq_pkg::*;
#(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               cont,
   input  logic [NUM_CH-1:0]  ch_mask,
   input  logic [DWELL_W-1:0] dwell,
   output logic [CH_W-1:0]    sel,
   output logic               sel_valid,
   output logic               busy,
   output logic               done,
   output logic               err_empty
);
   scan_state_t        state_q, state_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d, rel_q, rel_d, rel_in;
   logic [NUM_CH-1:0]  mask_q, mask_d;
   logic               cont_q, cont_d, err_d;
   logic [CH_W-1:0]    sel_d, lo_ch, step_ch;
   logic               lo_found, step_found;
   assign rel_in = (dwell == '0) ? '0 : dwell - 1'b1;
   // cur=7 with wrap yields the lowest enabled channel of the incoming mask
   scan_next_ch u_lo (
      .mask(ch_mask), .cur(3'd7), .wrap(1'b1), .nxt(lo_ch), .found(lo_found)
   );
   // Circular search in continuous mode returns the current channel when it is the only one
   scan_next_ch u_step (
      .mask(mask_q), .cur(sel), .wrap(cont_q), .nxt(step_ch), .found(step_found)
   );
   always_comb begin
      state_d = state_q;
      sel_d = sel;
      cnt_d = cnt_q;
      mask_d = mask_q;
      cont_d = cont_q;
      rel_d = rel_q;
      err_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && !stop) begin
               err_d = !lo_found;
               if (lo_found) begin
                  mask_d = ch_mask;
                  cont_d = cont;
                  rel_d = rel_in;
                  cnt_d = rel_in;
                  sel_d = lo_ch;
                  state_d = S_DWELL;
               end
            end
         end
         S_DWELL: begin
            if (stop) state_d = S_IDLE;
            else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            else if (step_found) begin
               sel_d = step_ch;
               cnt_d = rel_q;
            end else state_d = S_FINISH;
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sel <= '0;
         cnt_q <= '0;
         rel_q <= '0;
         mask_q <= '0;
         cont_q <= 1'b0;
         sel_valid <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         err_empty <= 1'b0;
      end else begin
         state_q <= state_d;
         sel <= (state_d == S_DWELL) ? sel_d : '0;
         cnt_q <= cnt_d;
         rel_q <= rel_d;
         mask_q <= mask_d;
         cont_q <= cont_d;
         sel_valid <= state_d == S_DWELL;
         busy <= state_d != S_IDLE;
         done <= state_d == S_FINISH;
         err_empty <= err_d;
      end
   end
endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: scoreboard bench; expected per-cycle outputs are queued when
// stimulus is driven and popped one per clock after the DUT updates
module tb_scan_sequencer;
   logic       clk, rst_n, start, stop, cont;
   logic [7:0] ch_mask, dwell;
   logic [2:0] sel;
   logic       sel_valid, busy, done, err_empty;
   logic [6:0] outs;
   logic [6:0] sb[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   string      cur_tag = "init";

   scan_sequencer #(.DWELL_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont),
      .ch_mask(ch_mask), .dwell(dwell), .sel(sel), .sel_valid(sel_valid),
      .busy(busy), .done(done), .err_empty(err_empty)
   );

   assign outs = {sel_valid, sel, busy, done, err_empty};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // packed as {sel_valid, sel, busy, done, err_empty}
   task automatic exp(input logic v, input logic [2:0] s, input logic b, input logic d, input logic e);
      sb.push_back({v, s, b, d, e});
   endtask

   task automatic exp_ch(input int s);
      exp(1'b1, 3'(s), 1'b1, 1'b0, 1'b0);
   endtask

   task automatic exp_done();
      exp(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic exp_idle();
      exp(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      logic [6:0] e;
      @(posedge clk);
      #1;
      start = 1'b0;
      stop = 1'b0;
      cyc++;
      chk($sformatf("%s c%0d sb_avail", cur_tag, cyc), 8'(sb.size() != 0), 8'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk($sformatf("%s c%0d outs", cur_tag, cyc), {1'b0, outs}, {1'b0, e});
      end
   endtask

   task automatic begin_test(input string tag);
      cur_tag = tag;
      cyc = 0;
   endtask

   initial begin
      int seq1[8] = '{0, 0, 2, 2, 5, 5, 7, 7};
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; cont = 1'b0; ch_mask = '0; dwell = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset outs", {1'b0, outs}, 8'd0);
      rst_n = 1'b1;

      begin_test("pass_a5");
      ch_mask = 8'hA5; dwell = 8'd2; cont = 1'b0; start = 1'b1;
      foreach (seq1[i]) exp_ch(seq1[i]);
      exp_done();
      exp_idle();
      repeat (10) tick();

      begin_test("wrap_81");
      ch_mask = 8'h81; dwell = 8'd0; cont = 1'b1; start = 1'b1;
      for (int i = 0; i < 6; i++) exp_ch(i[0] ? 7 : 0);
      repeat (6) tick();
      stop = 1'b1;
      exp_idle();
      exp_idle();
      repeat (2) tick();

      begin_test("empty");
      ch_mask = 8'h00; dwell = 8'd2; cont = 1'b0; start = 1'b1;
      exp(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
      exp_idle();
      repeat (2) tick();

      begin_test("single_10");
      ch_mask = 8'h10; dwell = 8'd3; cont = 1'b1; start = 1'b1;
      repeat (10) exp_ch(4);
      repeat (4) tick();
      ch_mask = 8'h01; dwell = 8'd0; cont = 1'b0; start = 1'b1;
      repeat (6) tick();
      stop = 1'b1;
      exp_idle();
      tick();

      begin_test("async_rst");
      ch_mask = 8'hA5; dwell = 8'd4; cont = 1'b1; start = 1'b1;
      exp_ch(0);
      exp_ch(0);
      repeat (2) tick();
      #3 rst_n = 1'b0;
      #1 chk("async_rst immediate", {1'b0, outs}, 8'd0);
      #2 rst_n = 1'b1;
      exp_idle();
      tick();
      ch_mask = 8'h24; dwell = 8'd1; cont = 1'b0; start = 1'b1;
      exp_ch(2);
      exp_ch(5);
      exp_done();
      exp_idle();
      repeat (4) tick();

      begin_test("start_stop");
      ch_mask = 8'hA5; dwell = 8'd1; cont = 1'b1; start = 1'b1; stop = 1'b1;
      exp_idle();
      exp_idle();
      repeat (2) tick();

      begin_test("live_mask");
      ch_mask = 8'h06; dwell = 8'd1; cont = 1'b0; start = 1'b1;
      exp_ch(1);
      exp_ch(2);
      exp_done();
      exp_idle();
      tick();
      ch_mask = 8'hFF; dwell = 8'd5; cont = 1'b1;
      repeat (3) tick();

      chk("sb drained", 8'(sb.size()), 8'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
